servo_pwm_array: RTL and testbench
==================================

SERVO_PWM_ARRAY -- requirements
Module: servo_pwm_array

Interface
REQ-001 SHALL have parameter FREQ, default 25_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter TARGET_FREQ, default 50, PWM frame rate in Hz; PERIOD = FREQ/TARGET_FREQ clocks.
REQ-003 SHALL have parameter N_CH, default 3, number of servo channels (1..16).
REQ-004 SHALL have parameter BIT_SIZE, default 10, width of each signed angle lane.
REQ-005 SHALL have parameters DC_MIN/DC_MID/DC_MAX, defaults 25_000/37_500/50_000, high-time in clocks at -COORD_MAX/0/+COORD_MAX.
REQ-006 SHALL have parameter COORD_MAX, default 270, angle clamp magnitude.
REQ-007 SHALL have parameter STEP, default 2_500, maximum duty change per channel per frame (slew).
REQ-008 SHALL have port clk, input, 1, sole clock.
REQ-009 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-010 SHALL have port angle_in, input, N_CH*BIT_SIZE, signed two's-complement lanes; lane i at bits [i*BIT_SIZE +: BIT_SIZE].
REQ-011 SHALL have ports in_valid (input, 1) and in_ready (output, 1), update handshake for all lanes at once.
REQ-012 SHALL have port pwm_out, output, N_CH, one PWM line per channel.
REQ-013 SHALL have port frame_start, output, 1, one-cycle pulse when the frame counter is 0.
REQ-014 SHALL have port at_target, output, N_CH, channel current duty equals target duty.
REQ-015 SHALL have port clipped, output, N_CH, sticky per-lane flag: last accepted angle exceeded ±COORD_MAX.

Function
REQ-016 Frame counter SHALL count 0..PERIOD-1 and wrap to 0 (no PERIOD+1-cycle frame).
REQ-017 Transfer occurs on clk edge where in_valid && in_ready; in_ready SHALL be high only when pending buffer empty.
REQ-018 On transfer each lane SHALL be clamped to [-COORD_MAX, +COORD_MAX] (|-2^(BIT_SIZE-1)| computed in BIT_SIZE+1 bits) and mapped to pending duty next cycle: a>=0 -> DC_MID + (DC_MAX-DC_MID)*a/COORD_MAX; a<0 -> DC_MID - (DC_MID-DC_MIN)*|a|/COORD_MAX; truncating division, 32-bit intermediates.
REQ-019 On cycle counter==PERIOD-1 with pending full, pending duty SHALL move to target and pending empties (in_ready high next cycle); mid-frame updates never alter the running frame.
REQ-020 On cycle counter==PERIOD-1 each current duty SHALL move toward its target by min(STEP, |target-current|), using the target value after REQ-019 applies on the same edge.
REQ-021 pwm_out[i] SHALL be registered, high when counter < current[i]; one-clock latency from counter.
REQ-022 at_target[i] SHALL be registered comparison current[i]==target[i].
REQ-023 in_valid while in_ready low SHALL be ignored (no overwrite of pending).

Reset
REQ-024 On rst: counter=0, current=target=DC_MID all channels, pending empty, in_ready=1 from first cycle after reset, pwm_out=0, frame_start=0, at_target=all 1, clipped=0.
REQ-025 rst asserted mid-frame SHALL force pwm_out low at the next edge and discard pending data.

Configuration
REQ-026 Macro SERVO_PWM_SLEW_EN defined: slew per REQ-020. Undefined: current SHALL take target directly at each frame boundary; STEP unused.

Structure
REQ-027 Package servo_pkg SHALL hold PERIOD calculation function, default DC/COORD constants, and duty width constant (32).
REQ-028 One sub-module servo_slew_ch SHALL be instantiated per channel (clamp/map, pending, target, current, at_target); counter shared in top.

Verification (PERIOD=100, DC_MIN/MID/MAX=25/50/75, COORD_MAX=270, STEP=10, N_CH=3, BIT_SIZE=10)
REQ-029 Reset then idle -> all pwm_out high 50 of every 100 clocks, frame_start every 100 clocks, in_ready=1.
REQ-030 Accept lanes {270,-270,135} -> targets {75,25,62}; with slew, ch0 high-time 60,70,75 over next frames, at_target[0] on third frame.
REQ-031 Accept lane0=500, lane1=-512 -> targets 75 and 25, clipped[1:0]=2'b11.
REQ-032 Second in_valid same frame after accept -> in_ready=0, ignored; first value applied at boundary.
REQ-033 rst at counter=30 during high phase -> pwm_out=0 next edge, counter restarts at 0, current=50.
REQ-034 Without SERVO_PWM_SLEW_EN, accept 270 -> ch0 high-time 75 in first full frame after boundary.

Source files
------------

// File: rtl/servo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : servo_pkg
// Description : Shared constants and helpers for the servo PWM array.
// Revision    : 1.0 - initial release
// ============================================================================
package servo_pkg;

  localparam int DUTY_W        = 32;
  localparam int DC_MIN_DEF    = 25_000;
  localparam int DC_MID_DEF    = 37_500;
  localparam int DC_MAX_DEF    = 50_000;
  localparam int COORD_MAX_DEF = 270;

  // Frame length in clocks for a given clock and frame rate.
  function automatic int calc_period(input int freq, input int target_freq);
    return freq / target_freq;
  endfunction

endpackage
`default_nettype wire

// File: rtl/servo_slew_ch.sv
`default_nettype none
// ============================================================================
// Module      : servo_slew_ch
// Description : One servo channel: clamp/map angle, pending/target/current
//               duty registers and at_target flag. SERVO_PWM_SLEW_EN enables
//               per-frame slew limiting of the current duty.
// Revision    : 1.0 - initial release
// ============================================================================
module servo_slew_ch
  import servo_pkg::*;
#(
  parameter int BIT_SIZE  = 10,
  parameter int DC_MIN    = DC_MIN_DEF,
  parameter int DC_MID    = DC_MID_DEF,
  parameter int DC_MAX    = DC_MAX_DEF,
  parameter int COORD_MAX = COORD_MAX_DEF,
  parameter int STEP      = 2_500
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BIT_SIZE-1:0] angle,
  input  logic                accept,
  input  logic                load,
  input  logic                frame_end,
  output logic [DUTY_W-1:0]   current,
  output logic                at_target,
  output logic                clipped
);

  localparam logic [DUTY_W-1:0] c_mid     = DUTY_W'(DC_MID);
  localparam logic [DUTY_W-1:0] c_hi_span = DUTY_W'(DC_MAX - DC_MID);
  localparam logic [DUTY_W-1:0] c_lo_span = DUTY_W'(DC_MID - DC_MIN);
  localparam logic [DUTY_W-1:0] c_coord   = DUTY_W'(COORD_MAX);

  logic signed [31:0] w_a;
  logic signed [31:0] w_clamped;
  logic [31:0]        w_mag;
  logic [DUTY_W-1:0]  w_map;
  logic               w_over;
  logic [DUTY_W-1:0]  w_next_target;
  logic [DUTY_W-1:0]  w_next_current;

  logic [DUTY_W-1:0]  r_pending;
  logic [DUTY_W-1:0]  r_target;
  logic [DUTY_W-1:0]  r_current;
  logic               r_at_target;
  logic               r_clipped;

  // Sign-extending to 32 bits keeps |-2^(BIT_SIZE-1)| representable.
  always_comb begin
    w_a       = 32'(signed'(angle));
    w_over    = 1'b0;
    w_clamped = w_a;
    if (w_a > COORD_MAX) begin
      w_clamped = COORD_MAX;
      w_over    = 1'b1;
    end else if (w_a < -COORD_MAX) begin
      w_clamped = -COORD_MAX;
      w_over    = 1'b1;
    end
    w_mag = (w_clamped < 0) ? 32'(-w_clamped) : 32'(w_clamped);
    if (w_clamped < 0) begin
      w_map = c_mid - (c_lo_span * w_mag) / c_coord;
    end else begin
      w_map = c_mid + (c_hi_span * w_mag) / c_coord;
    end
  end

`ifdef SERVO_PWM_SLEW_EN
  localparam logic [DUTY_W-1:0] c_step = DUTY_W'(STEP);
  logic [DUTY_W-1:0] w_diff;

  always_comb begin
    w_next_target  = load ? r_pending : r_target;
    w_diff         = '0;
    w_next_current = r_current;
    if (w_next_target > r_current) begin
      w_diff         = w_next_target - r_current;
      w_next_current = r_current + ((w_diff < c_step) ? w_diff : c_step);
    end else if (w_next_target < r_current) begin
      w_diff         = r_current - w_next_target;
      w_next_current = r_current - ((w_diff < c_step) ? w_diff : c_step);
    end
  end
`else
  logic [31:0] w_unused_step;
  assign w_unused_step = 32'(STEP);

  always_comb begin
    w_next_target  = load ? r_pending : r_target;
    w_next_current = w_next_target;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending   <= c_mid;
      r_target    <= c_mid;
      r_current   <= c_mid;
      r_at_target <= 1'b1;
      r_clipped   <= 1'b0;
    end else begin
      if (accept) begin
        r_pending <= w_map;
        r_clipped <= w_over;
      end
      if (frame_end) begin
        r_target  <= w_next_target;
        r_current <= w_next_current;
      end
      r_at_target <= (r_current == r_target);
    end
  end

  assign current   = r_current;
  assign at_target = r_at_target;
  assign clipped   = r_clipped;

endmodule
`default_nettype wire

// File: rtl/servo_pwm_array.sv
`default_nettype none
// ============================================================================
// Module      : servo_pwm_array
// Description : N_CH-channel servo PWM generator with shared frame counter and
//               a single handshake updating all angle lanes at once.
//               Optional slew limiting via SERVO_PWM_SLEW_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_array
  import servo_pkg::*;
#(
  parameter int FREQ        = 25_000_000,
  parameter int TARGET_FREQ = 50,
  parameter int N_CH        = 3,
  parameter int BIT_SIZE    = 10,
  parameter int DC_MIN      = DC_MIN_DEF,
  parameter int DC_MID      = DC_MID_DEF,
  parameter int DC_MAX      = DC_MAX_DEF,
  parameter int COORD_MAX   = COORD_MAX_DEF,
  parameter int STEP        = 2_500
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*BIT_SIZE-1:0] angle_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [N_CH-1:0]          pwm_out,
  output logic                     frame_start,
  output logic [N_CH-1:0]          at_target,
  output logic [N_CH-1:0]          clipped
);

  localparam int c_period = calc_period(FREQ, TARGET_FREQ);
  localparam int c_cnt_w  = (c_period > 1) ? $clog2(c_period) : 1;

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_pending_full;
  logic               r_frame_start;
  logic [N_CH-1:0]    r_pwm;

  logic               w_frame_end;
  logic               w_accept;
  logic               w_load;
  logic [N_CH-1:0]    w_pwm_next;
  logic [DUTY_W-1:0]  w_current [N_CH];

  assign w_frame_end = (r_cnt == c_cnt_w'(c_period - 1));
  assign w_accept    = in_valid && !r_pending_full;
  assign w_load      = w_frame_end && r_pending_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_pending_full <= 1'b0;
      r_frame_start  <= 1'b0;
      r_pwm          <= '0;
    end else begin
      r_cnt         <= w_frame_end ? '0 : r_cnt + 1'b1;
      r_frame_start <= (r_cnt == '0);
      r_pwm         <= w_pwm_next;
      // Accept needs an empty buffer, so it never coincides with a load.
      if (w_load) begin
        r_pending_full <= 1'b0;
      end else if (w_accept) begin
        r_pending_full <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    servo_slew_ch #(
      .BIT_SIZE  (BIT_SIZE),
      .DC_MIN    (DC_MIN),
      .DC_MID    (DC_MID),
      .DC_MAX    (DC_MAX),
      .COORD_MAX (COORD_MAX),
      .STEP      (STEP)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .angle     (angle_in[gi*BIT_SIZE +: BIT_SIZE]),
      .accept    (w_accept),
      .load      (w_load),
      .frame_end (w_frame_end),
      .current   (w_current[gi]),
      .at_target (at_target[gi]),
      .clipped   (clipped[gi])
    );

    assign w_pwm_next[gi] = (DUTY_W'(r_cnt) < w_current[gi]);
  end

  assign in_ready    = !r_pending_full;
  assign pwm_out     = r_pwm;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_servo_pwm_array
// Description : Directed self-checking bench for servo_pwm_array (PERIOD=100).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_pwm_array;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] angle_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  pwm_out;
  logic        frame_start;
  logic [2:0]  at_target;
  logic [2:0]  clipped;

  int total = 0;
  int bad   = 0;
  int h0, h1, h2, fs;

  servo_pwm_array #(
    .FREQ        (100),
    .TARGET_FREQ (1),
    .N_CH        (3),
    .BIT_SIZE    (10),
    .DC_MIN      (25),
    .DC_MID      (50),
    .DC_MAX      (75),
    .COORD_MAX   (270),
    .STEP        (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .angle_in    (angle_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .pwm_out     (pwm_out),
    .frame_start (frame_start),
    .at_target   (at_target),
    .clipped     (clipped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a0, input int a1, input int a2);
    logic [9:0] l0, l1, l2;
    l0 = 10'(a0);
    l1 = 10'(a1);
    l2 = 10'(a2);
    angle_in = {l2, l1, l0};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Align on a frame_start sample, then count high cycles over one frame.
  task automatic measure();
    int n = 0;
    while (frame_start !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) chk("frame_start_timeout", 32'(n), 32'(0));
    h0 = 0; h1 = 0; h2 = 0; fs = 0;
    for (int i = 0; i < 100; i++) begin
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      h2 += int'(pwm_out[2]);
      fs += int'(frame_start);
      step();
    end
  endtask

  initial begin
`ifdef SERVO_PWM_SLEW_EN
    int e3[3][3] = '{'{60, 40, 60}, '{70, 30, 62}, '{75, 25, 62}};
    int e3_at[3] = '{4, 7, 7};
    int e4[2]    = '{52, 50};
    int e6[2][3] = '{'{40, 50, 40}, '{38, 50, 30}};
`else
    int e3[3][3] = '{'{75, 25, 62}, '{75, 25, 62}, '{75, 25, 62}};
    int e3_at[3] = '{7, 7, 7};
    int e4[2]    = '{50, 50};
    int e6[2][3] = '{'{38, 50, 25}, '{38, 50, 25}};
`endif

    // Reset state
    step();
    step();
    chk("rst_pwm_out", 32'(pwm_out), 32'(0));
    chk("rst_frame_start", 32'(frame_start), 32'(0));
    chk("rst_at_target", 32'(at_target), 32'(7));
    chk("rst_clipped", 32'(clipped), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    rst = 1'b0;

    // Idle frames at mid duty
    measure();
    chk("idle_h0", 32'(h0), 32'(50));
    chk("idle_h1", 32'(h1), 32'(50));
    chk("idle_h2", 32'(h2), 32'(50));
    chk("idle_fs_per_frame", 32'(fs), 32'(1));
    chk("idle_next_fs", 32'(frame_start), 32'(1));
    chk("idle_in_ready", 32'(in_ready), 32'(1));

    // Full-scale lanes plus an ignored second update in the same frame
    send(270, -270, 135);
    chk("acc1_in_ready_low", 32'(in_ready), 32'(0));
    chk("acc1_at_target_pre", 32'(at_target), 32'(7));
    send(0, 0, 0);
    chk("acc1_ignored_in_ready", 32'(in_ready), 32'(0));
    for (int f = 0; f < 3; f++) begin
      measure();
      chk($sformatf("acc1_f%0d_h0", f), 32'(h0), 32'(e3[f][0]));
      chk($sformatf("acc1_f%0d_h1", f), 32'(h1), 32'(e3[f][1]));
      chk($sformatf("acc1_f%0d_h2", f), 32'(h2), 32'(e3[f][2]));
      chk($sformatf("acc1_f%0d_at_target", f), 32'(at_target), 32'(e3_at[f]));
    end
    chk("acc1_in_ready_after", 32'(in_ready), 32'(1));

    // Out-of-range lanes clip
    send(500, -512, 0);
    chk("acc2_clipped", 32'(clipped), 32'(3));
    for (int f = 0; f < 2; f++) begin
      measure();
      chk($sformatf("acc2_f%0d_h0", f), 32'(h0), 32'(75));
      chk($sformatf("acc2_f%0d_h1", f), 32'(h1), 32'(25));
      chk($sformatf("acc2_f%0d_h2", f), 32'(h2), 32'(e4[f]));
    end

    // Load pending, then reset mid high phase
    send(-135, 0, -270);
    chk("acc3_clipped_clear", 32'(clipped), 32'(0));
    for (int i = 0; i < 27; i++) step();
    chk("pre_rst_pwm0_high", 32'(pwm_out[0]), 32'(1));
    rst = 1'b1;
    step();
    chk("mid_rst_pwm_out", 32'(pwm_out), 32'(0));
    chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
    chk("mid_rst_at_target", 32'(at_target), 32'(7));
    rst = 1'b0;
    step();
    chk("post_rst_frame_start", 32'(frame_start), 32'(1));
    for (int f = 0; f < 2; f++) begin
      measure();
      chk($sformatf("post_rst_f%0d_h0", f), 32'(h0), 32'(50));
      chk($sformatf("post_rst_f%0d_h1", f), 32'(h1), 32'(50));
      chk($sformatf("post_rst_f%0d_h2", f), 32'(h2), 32'(50));
    end

    // Negative mapping with truncation
    send(-135, 0, -270);
    for (int f = 0; f < 2; f++) begin
      measure();
      chk($sformatf("neg_f%0d_h0", f), 32'(h0), 32'(e6[f][0]));
      chk($sformatf("neg_f%0d_h1", f), 32'(h1), 32'(e6[f][1]));
      chk($sformatf("neg_f%0d_h2", f), 32'(h2), 32'(e6[f][2]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
